// File: rtl/cpi_pkg.sv
// Shared types and constants for the CPI global link-connection controller.
package cpi_pkg;

  localparam int unsigned CPI_EPOCH_ID_WIDTH = 10;

  localparam logic [15:0] CPI_TIMEOUT_DEFAULT = 16'd1024;

  typedef enum logic [1:0] {
    DISC = 2'd0,
    CONN = 2'd1,
    UP   = 2'd2,
    DCON = 2'd3
  } link_state_t;

endpackage

// File: rtl/cpi_link_ctrl_if.sv
// CPI global channel between the agent (master) and the fabric (slave).
interface cpi_link_ctrl_if #(
  parameter int unsigned EPOCH_W = cpi_pkg::CPI_EPOCH_ID_WIDTH
);
  logic               txcon_req;
  logic               rxcon_ack;
  logic               rxdiscon_nack;
  logic               rx_empty;
  logic               fatal;
  logic               viral;
  logic [EPOCH_W-1:0] epoch_id;
  logic [EPOCH_W-1:0] epoch_commit;
  logic [EPOCH_W-1:0] epoch_reject;

  modport master (
    output txcon_req, fatal, viral, epoch_id, epoch_commit, epoch_reject,
    input  rxcon_ack, rxdiscon_nack, rx_empty
  );

  modport slave (
    input  txcon_req, fatal, viral, epoch_id, epoch_commit, epoch_reject,
    output rxcon_ack, rxdiscon_nack, rx_empty
  );
endinterface

// File: rtl/cpi_link_timer.sv
// Saturating handshake timer with synchronous clear; expired when count reaches LIMIT-1.
module cpi_link_timer #(
  parameter int unsigned     W     = 16,
  parameter logic [W-1:0]    LIMIT = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: flops use <= so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // LIMIT == 0 disables the timeout altogether.
  assign expired = (LIMIT != '0) && (count_q == (LIMIT - W'(1)));

endmodule

// File: rtl/cpi_link_ctrl.sv
// Agent-side CPI link-connection sequencer: connect/disconnect handshake,
// sticky fatal/viral flags and epoch bookkeeping for the A2F global channel.
module cpi_link_ctrl
  import cpi_pkg::*;
#(
  parameter int unsigned          EPOCH_W     = CPI_EPOCH_ID_WIDTH,
  parameter int unsigned          TIMEOUT_W   = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = TIMEOUT_W'(CPI_TIMEOUT_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            connect_req,
  input  logic            disconnect_req,
  input  logic            tx_idle,
  input  logic            err_fatal_in,
  input  logic            err_viral_in,
  input  logic            epoch_end,
  input  logic            epoch_ok,
  output logic [1:0]      link_state,
  output logic            link_up,
  cpi_link_ctrl_if.master cpi
);

  link_state_t        state_q, state_d;
  logic               txcon_req_q, txcon_req_d;
  logic               link_up_q, link_up_d;
  logic               fatal_q, fatal_d;
  logic               viral_q, viral_d;
  logic [EPOCH_W-1:0] epoch_id_q, epoch_id_d;
  logic [EPOCH_W-1:0] epoch_commit_q, epoch_commit_d;
  logic [EPOCH_W-1:0] epoch_reject_q, epoch_reject_d;
  logic               state_chg;
  logic               conn_expired;
  logic               dcon_expired;

  // Each handshake direction owns a timer that restarts on every state entry.
  assign state_chg = (state_d != state_q);

  cpi_link_timer #(.W(TIMEOUT_W), .LIMIT(TIMEOUT_CYC)) u_conn_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_chg),
    .en      (state_q == CONN),
    .expired (conn_expired)
  );

  cpi_link_timer #(.W(TIMEOUT_W), .LIMIT(TIMEOUT_CYC)) u_dcon_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_chg),
    .en      (state_q == DCON),
    .expired (dcon_expired)
  );

  always_comb begin
    state_d = state_q;
    fatal_d = fatal_q | err_fatal_in;
    viral_d = viral_q | err_viral_in;

    if (fatal_q) begin
      state_d = DISC;
    end else begin
      unique case (state_q)
        DISC: if (connect_req && !disconnect_req) state_d = CONN;
        CONN: begin
          if (cpi.rxcon_ack) begin
            state_d = UP;
          end else if (conn_expired) begin
            fatal_d = 1'b1;
            state_d = DISC;
          end
        end
        UP: begin
          // The fabric may only drop ack after we have asked to disconnect.
          if (!cpi.rxcon_ack) begin
            fatal_d = 1'b1;
            state_d = DISC;
          end else if (disconnect_req && tx_idle) begin
            state_d = DCON;
          end
        end
        DCON: begin
          if (cpi.rxdiscon_nack) begin
            state_d = UP;
          end else if (!cpi.rxcon_ack && cpi.rx_empty) begin
            state_d = DISC;
          end else if (dcon_expired) begin
            fatal_d = 1'b1;
            state_d = DISC;
          end
        end
        default: state_d = DISC;
      endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    txcon_req_d = (state_d == CONN) || (state_d == UP);
    link_up_d   = (state_d == UP);
  end

  always_comb begin
    epoch_id_d     = epoch_id_q;
    epoch_commit_d = epoch_commit_q;
    epoch_reject_d = epoch_reject_q;
    if ((state_q == UP) && epoch_end) begin
      if (epoch_ok) epoch_commit_d = epoch_id_q;
      else          epoch_reject_d = epoch_id_q;
      epoch_id_d = epoch_id_q + EPOCH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= DISC;
      txcon_req_q    <= 1'b0;
      link_up_q      <= 1'b0;
      fatal_q        <= 1'b0;
      viral_q        <= 1'b0;
      epoch_id_q     <= '0;
      epoch_commit_q <= '0;
      epoch_reject_q <= '0;
    end else begin
      state_q        <= state_d;
      txcon_req_q    <= txcon_req_d;
      link_up_q      <= link_up_d;
      fatal_q        <= fatal_d;
      viral_q        <= viral_d;
      epoch_id_q     <= epoch_id_d;
      epoch_commit_q <= epoch_commit_d;
      epoch_reject_q <= epoch_reject_d;
    end
  end

  assign link_state       = state_q;
  assign link_up          = link_up_q;
  assign cpi.txcon_req    = txcon_req_q;
  assign cpi.fatal        = fatal_q;
  assign cpi.viral        = viral_q;
  assign cpi.epoch_id     = epoch_id_q;
  assign cpi.epoch_commit = epoch_commit_q;
  assign cpi.epoch_reject = epoch_reject_q;

endmodule

// File: tb/tb_cpi_link_ctrl.sv
// Directed bench for cpi_link_ctrl: vector table for the handshake walk,
// hand sequences for timeout, epoch wrap, fatal injection and async reset.
module tb_cpi_link_ctrl;

  localparam int unsigned EPOCH_W = 10;

  logic       clk;
  logic       rst_n;
  logic       connect_req, disconnect_req, tx_idle;
  logic       err_fatal_in, err_viral_in, epoch_end, epoch_ok;
  logic [1:0] link_state;
  logic       link_up;

  int checks = 0;
  int errors = 0;

  cpi_link_ctrl_if #(.EPOCH_W(EPOCH_W)) cpi ();

  cpi_link_ctrl #(
    .EPOCH_W     (EPOCH_W),
    .TIMEOUT_W   (16),
    .TIMEOUT_CYC (16'd8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .connect_req    (connect_req),
    .disconnect_req (disconnect_req),
    .tx_idle        (tx_idle),
    .err_fatal_in   (err_fatal_in),
    .err_viral_in   (err_viral_in),
    .epoch_end      (epoch_end),
    .epoch_ok       (epoch_ok),
    .link_state     (link_state),
    .link_up        (link_up),
    .cpi            (cpi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit cr, dr, idle, ee, eok, ack, nack, empty, ef, ev;
    int st;
    bit tx, up, fat, vir;
    int id, com, rej;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    connect_req       = 1'b0;
    disconnect_req    = 1'b0;
    tx_idle           = 1'b0;
    err_fatal_in      = 1'b0;
    err_viral_in      = 1'b0;
    epoch_end         = 1'b0;
    epoch_ok          = 1'b0;
    cpi.rxcon_ack     = 1'b0;
    cpi.rxdiscon_nack = 1'b0;
    cpi.rx_empty      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic check_all(input string tag, input int idx, input int st, input int tx,
                           input int up, input int fat, input int vir,
                           input int id, input int com, input int rej);
    check({tag, ".state"},  idx, int'(link_state),       st);
    check({tag, ".txcon"},  idx, int'(cpi.txcon_req),    tx);
    check({tag, ".up"},     idx, int'(link_up),          up);
    check({tag, ".fatal"},  idx, int'(cpi.fatal),        fat);
    check({tag, ".viral"},  idx, int'(cpi.viral),        vir);
    check({tag, ".id"},     idx, int'(cpi.epoch_id),     id);
    check({tag, ".commit"}, idx, int'(cpi.epoch_commit), com);
    check({tag, ".reject"}, idx, int'(cpi.epoch_reject), rej);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          cr dr id ee ok ak nk em ef ev | st tx up fa vi id com rej
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 0, 0, 0, 1, 0, 1, 0, 0,  2, 1, 1, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 1, 1, 1, 0, 1, 0, 0,  2, 1, 1, 0, 0, 1, 0, 0};
    vecs[5]  = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 0,  2, 1, 1, 0, 0, 2, 0, 1};
    vecs[6]  = '{0, 0, 0, 1, 1, 1, 0, 1, 0, 0,  2, 1, 1, 0, 0, 3, 2, 1};
    vecs[7]  = '{0, 1, 0, 0, 0, 1, 0, 1, 0, 0,  2, 1, 1, 0, 0, 3, 2, 1};
    vecs[8]  = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 0,  3, 0, 0, 0, 0, 3, 2, 1};
    vecs[9]  = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 0,  2, 1, 1, 0, 0, 3, 2, 1};
    vecs[10] = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 0,  3, 0, 0, 0, 0, 3, 2, 1};
    vecs[11] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0,  2, 1, 1, 0, 0, 3, 2, 1};
    vecs[12] = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 0,  3, 0, 0, 0, 0, 3, 2, 1};
    vecs[13] = '{0, 0, 0, 1, 1, 1, 0, 1, 0, 0,  3, 0, 0, 0, 0, 3, 2, 1};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 3, 2, 1};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 3, 2, 1};
    vecs[16] = '{0, 0, 0, 1, 1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 3, 2, 1};
    vecs[17] = '{1, 1, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 3, 2, 1};
    vecs[18] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 3, 2, 1};
    vecs[19] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0,  2, 1, 1, 0, 0, 3, 2, 1};
    vecs[20] = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 0,  2, 1, 1, 0, 0, 4, 2, 3};
    vecs[21] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1,  2, 1, 1, 0, 1, 4, 2, 3};
    vecs[22] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 1, 4, 2, 3};
    vecs[23] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 1, 4, 2, 3};

    do_reset();
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Handshake walk: connect, epochs, nack, clean disconnect, reconnect, ack drop.
    for (int i = 0; i < NV; i++) begin
      connect_req       = vecs[i].cr;
      disconnect_req    = vecs[i].dr;
      tx_idle           = vecs[i].idle;
      epoch_end         = vecs[i].ee;
      epoch_ok          = vecs[i].eok;
      cpi.rxcon_ack     = vecs[i].ack;
      cpi.rxdiscon_nack = vecs[i].nack;
      cpi.rx_empty      = vecs[i].empty;
      err_fatal_in      = vecs[i].ef;
      err_viral_in      = vecs[i].ev;
      step();
      check_all("vec", i, vecs[i].st, vecs[i].tx, vecs[i].up, vecs[i].fat,
                vecs[i].vir, vecs[i].id, vecs[i].com, vecs[i].rej);
    end

    // Timeout: 8 cycles in CONN without ack raises fatal and returns to DISC.
    do_reset();
    connect_req = 1'b1;
    step();
    check("to.enter", 0, int'(link_state), 1);
    for (int i = 1; i < 8; i++) begin
      step();
      check("to.conn_state", i, int'(link_state), 1);
      check("to.conn_fatal", i, int'(cpi.fatal), 0);
    end
    step();
    check("to.fatal", 0, int'(cpi.fatal), 1);
    check("to.state", 0, int'(link_state), 0);
    check("to.txcon", 0, int'(cpi.txcon_req), 0);
    repeat (3) step();
    check("to.ignored", 0, int'(link_state), 0);

    // Epoch wrap: 1023 alternating closes, then two more through the wrap.
    do_reset();
    connect_req = 1'b1;
    step();
    cpi.rxcon_ack = 1'b1;
    connect_req   = 1'b0;
    step();
    check("ep.up", 0, int'(link_state), 2);
    epoch_end = 1'b1;
    for (int i = 0; i < 1023; i++) begin
      epoch_ok = ((i % 2) == 0);
      step();
    end
    check("ep.id", 1023, int'(cpi.epoch_id), 1023);
    check("ep.commit", 1023, int'(cpi.epoch_commit), 1022);
    check("ep.reject", 1023, int'(cpi.epoch_reject), 1021);
    epoch_ok = 1'b0;
    step();
    check("ep.id", 1024, int'(cpi.epoch_id), 0);
    check("ep.commit", 1024, int'(cpi.epoch_commit), 1022);
    check("ep.reject", 1024, int'(cpi.epoch_reject), 1023);
    epoch_ok = 1'b1;
    step();
    check("ep.id", 1025, int'(cpi.epoch_id), 1);
    check("ep.commit", 1025, int'(cpi.epoch_commit), 0);
    check("ep.reject", 1025, int'(cpi.epoch_reject), 1023);
    epoch_end = 1'b0;

    // Local fatal pulse in UP: flag first, DISC one cycle later.
    err_fatal_in = 1'b1;
    step();
    err_fatal_in = 1'b0;
    check("ef.fatal", 0, int'(cpi.fatal), 1);
    check("ef.state", 0, int'(link_state), 2);
    step();
    check("ef.state", 1, int'(link_state), 0);
    check("ef.txcon", 1, int'(cpi.txcon_req), 0);
    check("ef.id_hold", 1, int'(cpi.epoch_id), 1);

    // Asynchronous reset mid-CONN with a coincident viral pulse.
    do_reset();
    connect_req = 1'b1;
    step();
    check("ar.conn", 0, int'(cpi.txcon_req), 1);
    #3;
    rst_n        = 1'b0;
    err_viral_in = 1'b1;
    #1;
    check_all("ar.async", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    err_viral_in = 1'b0;
    connect_req  = 1'b0;
    step();
    #3 rst_n = 1'b1;
    step();
    check_all("ar.release", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    err_viral_in = 1'b1;
    step();
    err_viral_in = 1'b0;
    check("ar.viral", 0, int'(cpi.viral), 1);
    check("ar.state", 0, int'(link_state), 0);
    step();
    check("ar.viral_sticky", 0, int'(cpi.viral), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
